// File: rtl/half_argmax_pkg.sv
// Shared types and binary16 helpers for the half-precision argmax block.
package half_argmax_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] HALF_NEG_INF = 16'hFC00;

  function automatic logic half_is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'h000);
  endfunction

  // Monotonic unsigned ordering key; -0 is folded onto +0 so they tie.
  function automatic logic [15:0] half_key(input logic [15:0] h);
    if (h == 16'h8000) begin
      return 16'h8000;
    end
    return h[15] ? ~h : (h | 16'h8000);
  endfunction

endpackage

// File: rtl/half_key_gt.sv
// Strict greater-than on binary16 values; any NaN ranks below every number.
module half_key_gt
  import half_argmax_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        a_gt_b
);

  always_comb begin
    a_gt_b = 1'b0;
    if (half_is_nan(a)) begin
      a_gt_b = 1'b0;
    end else if (half_is_nan(b)) begin
      a_gt_b = 1'b1;
    end else begin
      a_gt_b = (half_key(a) > half_key(b));
    end
  end

endmodule

// File: rtl/half_argmax.sv
// Sequential argmax over OUTPUT_NODES binary16 scores, one compare per cycle.
// Optional winning-score output enabled by macro HALF_ARGMAX_SCORE_EN.
module half_argmax
  import half_argmax_pkg::*;
#(
  parameter int OUTPUT_NODES = 10,
  parameter int IDX_W        = $clog2(OUTPUT_NODES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [16*OUTPUT_NODES-1:0] y,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          class_idx,
  output logic                      nan_seen
`ifdef HALF_ARGMAX_SCORE_EN
  ,
  output logic [15:0]               class_score
`endif
);

  localparam int CW = (IDX_W < 1) ? 1 : IDX_W;
  localparam logic [CW-1:0] LAST = CW'(OUTPUT_NODES - 1);

  state_t              state_reg;
  logic [15:0]         y_arr   [OUTPUT_NODES];
  logic [15:0]         buf_mem [OUTPUT_NODES];
  logic [15:0]         best_reg;
  logic [15:0]         rd_reg;
  logic [IDX_W-1:0]    best_idx_reg;
  logic [CW-1:0]       cnt_reg;
  logic [CW-1:0]       rd_ptr_reg;
  logic                rd_vld_reg;
  logic                nan_reg;
  logic                rd_gt_best;

  generate
    for (genvar gi = 0; gi < OUTPUT_NODES; gi++) begin : g_unpack
      assign y_arr[gi] = y[16*gi +: 16];
    end
  endgenerate

  half_key_gt u_gt (
    .a      (rd_reg),
    .b      (best_reg),
    .a_gt_b (rd_gt_best)
  );

  // Buffer reads are registered, so comparison of index cnt trails its read
  // by one cycle; rd_vld_reg marks the first SCAN cycle as read-only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      best_reg     <= 16'h0000;
      best_idx_reg <= '0;
      nan_reg      <= 1'b0;
      cnt_reg      <= '0;
      rd_ptr_reg   <= '0;
      rd_vld_reg   <= 1'b0;
      rd_reg       <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < OUTPUT_NODES; i++) begin
              buf_mem[i] <= y_arr[i];
            end
            best_reg     <= y_arr[0];
            best_idx_reg <= '0;
            nan_reg      <= half_is_nan(y_arr[0]);
            cnt_reg      <= CW'(1);
            rd_ptr_reg   <= CW'(1);
            rd_vld_reg   <= 1'b0;
            state_reg    <= (OUTPUT_NODES == 1) ? DONE : SCAN;
          end
        end
        SCAN: begin
          rd_reg     <= buf_mem[rd_ptr_reg];
          rd_vld_reg <= 1'b1;
          if (rd_ptr_reg != LAST) begin
            rd_ptr_reg <= rd_ptr_reg + CW'(1);
          end
          if (rd_vld_reg) begin
            if (rd_gt_best) begin
              best_reg     <= rd_reg;
              best_idx_reg <= cnt_reg[IDX_W-1:0];
            end
            nan_reg <= nan_reg | half_is_nan(rd_reg);
            cnt_reg <= cnt_reg + CW'(1);
            if (cnt_reg == LAST) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign class_idx = best_idx_reg;
  assign nan_seen  = nan_reg;
`ifdef HALF_ARGMAX_SCORE_EN
  assign class_score = best_reg;
`endif

endmodule

// File: tb/tb_half_argmax.sv
// Self-checking bench for half_argmax: real-valued reference model, directed
// corner vectors and a randomized phase with backpressure and resets.
module tb_half_argmax;

  localparam int N  = 10;
  localparam int IW = 4;
  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_DONE = 2;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic [16*N-1:0] y;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   class_idx;
  logic            nan_seen;
`ifdef HALF_ARGMAX_SCORE_EN
  logic [15:0]     class_score;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  int          m_state = M_IDLE;
  int          m_left  = 0;
  bit          m_live  = 0;
  bit          m_after_rst = 0;
  int          exp_idx = 0;
  bit          exp_nan = 0;
  logic [15:0] exp_score = 16'h0000;

  logic [15:0] dv [N];

  half_argmax #(.OUTPUT_NODES(N), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .y         (y),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .class_idx (class_idx),
    .nan_seen  (nan_seen)
`ifdef HALF_ARGMAX_SCORE_EN
    ,
    .class_score (class_score)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_nan(input logic [15:0] h);
    return (h[14:10] == 5'd31) && (h[9:0] != 10'd0);
  endfunction

  // Numeric value of a binary16 (infinities as +/-1e30).
  function automatic real h2r(input logic [15:0] h);
    int  e;
    int  sh;
    real v;
    e = int'(h[14:10]);
    if (e == 31) begin
      v = 1.0e30;
    end else begin
      v  = (e == 0) ? real'(int'(h[9:0])) : real'(1024 + int'(h[9:0]));
      sh = (e == 0) ? 1 : e;
      for (int k = 0; k < sh; k++) v = v * 2.0;
      v = v / 33554432.0;
    end
    return h[15] ? -v : v;
  endfunction

  function automatic void ref_argmax(input logic [16*N-1:0] v, output int idx, output bit nan);
    logic [15:0] e;
    logic [15:0] b;
    idx = 0;
    nan = is_nan(v[15:0]);
    for (int i = 1; i < N; i++) begin
      e = v[16*i +: 16];
      b = v[16*idx +: 16];
      if (is_nan(e)) nan = 1'b1;
      else if (is_nan(b) || h2r(e) > h2r(b)) idx = i;
    end
  endfunction

  // Protocol-level expectation: result appears N edges after acceptance.
  always @(posedge clk) begin
    int i;
    bit n;
    if (rst) begin
      m_state = M_IDLE;
      m_live = 1'b1;
      m_after_rst = 1'b1;
      exp_idx = 0;
      exp_nan = 1'b0;
      exp_score = 16'h0000;
    end else begin
      case (m_state)
        M_IDLE: if (in_valid) begin
          ref_argmax(y, i, n);
          exp_idx = i;
          exp_nan = n;
          exp_score = y[16*i +: 16];
          m_after_rst = 1'b0;
          m_left = N;
          m_state = (N == 1) ? M_DONE : M_BUSY;
        end
        M_BUSY: begin
          m_left--;
          if (m_left == 0) m_state = M_DONE;
        end
        M_DONE: if (out_ready) m_state = M_IDLE;
        default: m_state = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", in_ready, m_state == M_IDLE);
      chk("out_valid", out_valid, m_state == M_DONE);
      if (m_state == M_DONE || m_after_rst) begin
        chk("class_idx", class_idx, exp_idx);
        chk("nan_seen", nan_seen, exp_nan);
`ifdef HALF_ARGMAX_SCORE_EN
        chk("class_score", class_score, exp_score);
`endif
      end
    end
  end

  task automatic pack_dv();
    for (int i = 0; i < N; i++) y[16*i +: 16] = dv[i];
  endtask

  task automatic fill_dv(input logic [15:0] v);
    for (int i = 0; i < N; i++) dv[i] = v;
  endtask

  task automatic run_vec(input string nm, input int lit_idx, input bit lit_nan, input bit hold);
    int lat;
    pack_dv();
    in_valid  = 1'b1;
    out_ready = !hold;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, N);
    chk({nm, "_idx"}, class_idx, lit_idx);
    chk({nm, "_nan"}, nan_seen, lit_nan);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        if (k == 2) begin
          y = {N{16'h7C00}};
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk({nm, "_hold_idx"}, class_idx, lit_idx);
        chk({nm, "_hold_ready"}, in_ready, 1'b0);
        chk({nm, "_hold_valid"}, out_valid, 1'b1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk({nm, "_ready_back"}, in_ready, 1'b1);
  endtask

  function automatic logic [15:0] rnd_half();
    case ($urandom_range(0, 7))
      0: return 16'h3C00;
      1: return 16'h0000;
      2: return 16'h8000;
      3: return 16'h7E00;
      4: return 16'hFC00;
      5: return 16'h7C00;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    y = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_idx", class_idx, 0);

    fill_dv(16'h0000);
    dv[0] = 16'h3C00; dv[1] = 16'h4000; dv[2] = 16'hC000; dv[3] = 16'h3800;
    run_vec("basic", 1, 1'b0, 1'b0);
`ifdef HALF_ARGMAX_SCORE_EN
    chk("basic_score", class_score, 16'h4000);
`endif

    fill_dv(16'h3C00);
    run_vec("all_equal", 0, 1'b0, 1'b0);
    dv[3] = 16'h4400; dv[7] = 16'h4400;
    run_vec("tie_low", 3, 1'b0, 1'b0);

    fill_dv(16'hFC00);
    dv[0] = 16'h7E00;
    run_vec("nan_first", 1, 1'b1, 1'b0);
    fill_dv(16'h7E00);
    run_vec("all_nan", 0, 1'b1, 1'b0);

    fill_dv(16'hBC00);
    dv[0] = 16'h8000; dv[1] = 16'h0000;
    run_vec("zeros", 0, 1'b0, 1'b0);

    fill_dv(16'h0000);
    dv[0] = 16'h3C00; dv[1] = 16'h4000; dv[2] = 16'hC000; dv[3] = 16'h3800;
    run_vec("hold", 1, 1'b0, 1'b1);

    // Reset part-way through a scan, then a vector whose maximum is last.
    fill_dv(16'h4000);
    pack_dv();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_idx", class_idx, 0);
    fill_dv(16'h0000);
    dv[9] = 16'h3C00;
    run_vec("last_idx", 9, 1'b0, 1'b0);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) y[16*i +: 16] = rnd_half();
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3 * N) @(posedge clk);
    #1;
    chk("drain_in_ready", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/half_argmax.md
HALF_ARGMAX -- requirements
Module: half_argmax

Interface
REQ-001 The block SHALL have parameter OUTPUT_NODES, default 10, giving the number of half-precision scores per vector.
REQ-002 The block SHALL have parameter IDX_W, default $clog2(OUTPUT_NODES), giving the width of the class index.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning y holds a score vector (driven by the predictor's out_valid).
REQ-006 The block SHALL have port y, input, 16 bits x OUTPUT_NODES, IEEE binary16 scores.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a vector this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning the result is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-010 The block SHALL have port class_idx, output, IDX_W bits, index of the maximum score.
REQ-011 The block SHALL have port nan_seen, output, 1 bit, set when any score in the vector was NaN.
REQ-012 The block SHALL have port class_score, output, 16 bits, the winning score, present only under HALF_ARGMAX_SCORE_EN.

Function
REQ-013 The FSM SHALL have states IDLE, SCAN and DONE; in_ready SHALL equal (state==IDLE) and out_valid SHALL equal (state==DONE).
REQ-014 In IDLE with in_valid=1, the block SHALL capture all of y into an internal buffer, load best=y[0], best_idx=0, cnt=1 and go to SCAN; y is not sampled again.
REQ-015 In SCAN, the block SHALL compare one buffered element per cycle at index cnt, replacing best/best_idx only when the element is strictly greater, then increment cnt.
REQ-016 SCAN SHALL go to DONE on the cycle it processes index OUTPUT_NODES-1, so out_valid first rises exactly OUTPUT_NODES cycles after the accepting edge.
REQ-017 When OUTPUT_NODES==1, the block SHALL go from IDLE directly to DONE with class_idx=0.
REQ-018 DONE SHALL hold class_idx, nan_seen and class_score stable until out_valid&&out_ready, then go to IDLE on that edge; a new vector is accepted no earlier than the following cycle.
REQ-019 in_valid while not in IDLE SHALL be ignored (no capture, no state change); the upstream holds or drops data at its discretion.
REQ-020 Ordering SHALL use key = bits[15] ? ~bits : bits|16'h8000, compared unsigned, with +0 and -0 mapped to equal keys.
REQ-021 A NaN (exponent 5'h1F, mantissa non-zero) SHALL rank below every non-NaN value including -Inf, and SHALL set nan_seen.
REQ-022 On ties the lowest index SHALL win; with all elements NaN, class_idx SHALL be 0.

Reset
REQ-023 rst=1 at any clock edge SHALL force IDLE, class_idx=0, nan_seen=0, class_score=16'h0000 (if present), in_ready=1 on the next cycle and out_valid=0; an in-progress scan is discarded without output.
REQ-024 in_valid SHALL be ignored on any edge where rst=1.

Configuration
REQ-025 With macro HALF_ARGMAX_SCORE_EN defined, class_score SHALL exist and SHALL carry the raw 16-bit winning value (sign of zero preserved from the winning element).
REQ-026 Without HALF_ARGMAX_SCORE_EN, the class_score port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 Package half_argmax_pkg SHALL hold the state enum, the half_key function, a half_is_nan function and the constant HALF_NEG_INF=16'hFC00.
REQ-028 The comparison SHALL be a sub-module half_key_gt (inputs a, b: 16 bits; output a_gt_b, NaN-aware per REQ-020..REQ-022); the rest of the block is a single module.

Verification
REQ-029 y={1.0(3C00), 2.0(4000), -2.0(C000), 0.5(3800), 0,...} with out_ready=1 SHALL produce class_idx=1 and out_valid exactly 10 cycles after acceptance, nan_seen=0, class_score=4000.
REQ-030 All elements 3C00 SHALL produce class_idx=0; y[3]=y[7]=4400 with the rest 3C00 SHALL produce class_idx=3.
REQ-031 y[0]=7E00 (NaN), y[5]=FC00 (-Inf), rest FC00 SHALL produce class_idx=1 and nan_seen=1; all elements 7E00 SHALL produce class_idx=0 and nan_seen=1.
REQ-032 y[0]=8000, y[1]=0000, rest BC00 SHALL produce class_idx=0 (equal zeros, lowest index wins).
REQ-033 With out_ready=0 for 5 cycles after out_valid rises, outputs SHALL stay stable and in_ready=0, and a pulsed in_valid with new data SHALL be ignored; raising out_ready SHALL return in_ready=1 on the next cycle.
REQ-034 Asserting rst at cycle 4 of a scan SHALL give out_valid=0, in_ready=1 and class_idx=0 on the next cycle; a following vector {0,...,0,3C00 at index 9} SHALL produce class_idx=9.
